trace_capture: RTL
==================

Name: trace_capture

Overview:
- Commit-trace recorder downstream of the RISC-V core top.
- Samples the core's per-cycle execution signals: PC, fetched instruction, register write-back data, ALU result/memory address, RAM write data and control enables.
- Packs each sample into a 5-word record, buffers records in a FIFO, and drains them as 32-bit words over a valid/ready stream to a bench scoreboard or a UART bridge.
- Capture is armed by software and starts on a PC trigger; the pipeline is never stalled.

Parameters:
- DEPTH, 16, FIFO depth in records; power of 2, at least 2.
- TRIG_PC, 32'h0000_0000, PC value that starts capture once armed.
- MAX_REC, 64, records captured per session before auto-stop; 0 means unlimited.

Ports:
- reloj  input  1  clock
- reset  input  1  asynchronous active-low reset
- arm  input  1  one-cycle pulse: IDLE/DONE -> ARMED
- stop  input  1  one-cycle pulse: ARMED/CAPTURE -> DONE
- PC_addr  input  32  PC of the instruction in the current cycle
- instr_rom  input  32  instruction fetched at PC_addr
- datareg_wr_sig  input  32  register file write data
- alu_result  input  32  ALU result / data RAM address
- dataram_wr_sig  input  32  data RAM write data
- MemtoReg_mux  input  1  write-back selects RAM
- ena_wr_sig  input  1  RAM write enable
- ena_rd_sig  input  1  RAM read enable
- tr_data  output  32  stream word
- tr_valid  output  1  stream word valid
- tr_last  output  1  last word of a record
- tr_ready  input  1  sink ready
- state  output  2  00 IDLE, 01 ARMED, 10 CAPTURE, 11 DONE
- level  output  $clog2(DEPTH)+1  records held
- drop_cnt  output  16  records dropped on full FIFO; saturating

Behaviour:
- Reset (reset=0, asynchronous): state=IDLE, FIFO empty, level=0, tr_valid=0, tr_last=0, tr_data=0, drop_cnt=0, seq=0, record count=0, word index=0.
- Capture FSM:
  - IDLE --arm--> ARMED. arm also clears seq, record count and drop_cnt. The FIFO is not flushed.
  - ARMED --(PC_addr==TRIG_PC)--> CAPTURE. The trigger cycle itself is recorded.
  - CAPTURE --(stop, or record count reaches MAX_REC)--> DONE.
  - ARMED --stop--> DONE.
  - DONE --arm--> ARMED.
  - arm in ARMED or CAPTURE is ignored. stop in IDLE or DONE is ignored. If arm and stop are high together, stop wins.
- Sampling:
  - In CAPTURE, exactly one record per reloj edge, including the trigger edge.
  - A record is pushed when the FIFO is not full, or when a pop completes in the same cycle.
  - Otherwise the record is dropped and drop_cnt increments, saturating at 16'hFFFF.
  - seq (24-bit, wraps) and record count advance on every sampled cycle, pushed or dropped, so gaps in seq expose drops.
  - The edge that reaches MAX_REC is sampled; no sample is taken in DONE.
- Record layout, words W0..W4 in stream order:
  - W0 = PC_addr
  - W1 = instr_rom
  - W2 = datareg_wr_sig
  - W3 = alu_result if (ena_wr_sig | ena_rd_sig), else dataram_wr_sig
  - W4 = {ena_wr_sig, ena_rd_sig, MemtoReg_mux, 5'b0, seq[23:0]}
- Drain:
  - tr_valid=1 whenever the FIFO is non-empty. tr_data is the current word of the head record.
  - A word transfers on a cycle with tr_valid & tr_ready; the word index then advances.
  - tr_last=1 on W4 only. The head record pops when W4 transfers, and the index returns to 0.
  - Words are registered, so tr_data and tr_last change only after a transfer or a new head.
  - tr_data must stay stable while tr_valid=1 and tr_ready=0.
  - Draining continues in every state, including IDLE and DONE.
- level is updated on the edge following push/pop. Push and pop in the same cycle leave level unchanged.
- Latency: a record pushed at edge N presents W0 at tr_valid from edge N+1, if the FIFO was empty.
- FIFO pointers wrap modulo DEPTH. Full means level==DEPTH.

Test Plan:
1. arm; PC_addr steps 0x0,0x4,0x8; stop after 3 cycles -> 3 records, 15 words with tr_ready=1; W0 sequence 0,4,8; W4[23:0] = 0,1,2; state=DONE; drop_cnt=0.
2. TRIG_PC=0x20; arm; PC runs 0x0..0x40 -> first W0=0x20; no earlier PCs appear.
3. Load cycle: ena_rd_sig=1, MemtoReg_mux=1, alu_result=0x100, datareg_wr_sig=0xDEAD -> W2=0xDEAD, W3=0x100, W4[31:29]=3'b011. Store cycle: ena_wr_sig=1 -> W4[31]=1.
4. tr_ready=0, DEPTH=16, 20 capture cycles -> level=16, drop_cnt=4; after release, 16 records drain with seq 0..15.
5. tr_ready toggling 1,0,1,0 -> each word held stable while stalled; tr_last asserted only on every 5th transfer.
6. Assert reset for one cycle mid-record (word index 2) -> tr_valid=0, level=0, state=IDLE immediately; no partial record appears after reset release.

Source files
------------

// File: rtl/trace_capture.sv
// Commit-trace recorder: samples the core's per-cycle execution signals into
// 5-word records, buffers them in a FIFO and drains them over a valid/ready stream.
module trace_capture #(
   parameter int unsigned DEPTH   = 16,
   parameter logic [31:0] TRIG_PC = 32'h0000_0000,
   parameter int unsigned MAX_REC = 64
) (
   input  logic                       reloj,
   input  logic                       reset,
   input  logic                       arm,
   input  logic                       stop,
   input  logic [31:0]                PC_addr,
   input  logic [31:0]                instr_rom,
   input  logic [31:0]                datareg_wr_sig,
   input  logic [31:0]                alu_result,
   input  logic [31:0]                dataram_wr_sig,
   input  logic                       MemtoReg_mux,
   input  logic                       ena_wr_sig,
   input  logic                       ena_rd_sig,
   output logic [31:0]                tr_data,
   output logic                       tr_valid,
   output logic                       tr_last,
   input  logic                       tr_ready,
   output logic [1:0]                 state,
   output logic [$clog2(DEPTH):0]     level,
   output logic [15:0]                drop_cnt
);

   localparam int unsigned AW = $clog2(DEPTH);
   localparam int unsigned LW = AW + 1;
   localparam logic [LW-1:0] FULL_LVL = LW'(DEPTH);
   localparam logic [31:0]   LAST_CNT = (MAX_REC == 0) ? 32'd0 : 32'(MAX_REC - 1);

   typedef enum logic [1:0] {
      IDLE    = 2'b00,
      ARMED   = 2'b01,
      CAPTURE = 2'b10,
      DONE    = 2'b11
   } state_t;

   // Word 0 of a record sits in element [0] so the word index selects directly.
   typedef logic [4:0][31:0] rec_t;

   state_t          st;
   rec_t            mem [DEPTH];
   logic [AW-1:0]   wr_ptr;
   logic [AW-1:0]   rd_ptr;
   logic [2:0]      idx;
   logic [23:0]     seq;
   logic [31:0]     rec_cnt;

   logic            xfer;
   logic            pop;
   logic            full;
   logic            stop_hit;
   logic            arm_hit;
   logic            sample;
   logic            push;
   logic            cap_end;
   logic            avail;
   logic [AW-1:0]   rd_next;
   logic [2:0]      idx_next;
   logic [LW-1:0]   kept;
   rec_t            rec_in;
   rec_t            head_next;

   assign state = st;

   // NOTE: every always_comb output gets a default first so no path can infer a latch.
   always_comb begin
      xfer      = tr_valid & tr_ready;
      pop       = xfer & tr_last;
      full      = (level == FULL_LVL);
      stop_hit  = stop & ((st == ARMED) | (st == CAPTURE));
      arm_hit   = arm & ~stop & ((st == IDLE) | (st == DONE));
      sample    = ~stop_hit & ((st == CAPTURE) | ((st == ARMED) & (PC_addr == TRIG_PC)));
      push      = sample & (~full | pop);
      cap_end   = (MAX_REC != 0) & (rec_cnt == LAST_CNT);

      rec_in[0] = PC_addr;
      rec_in[1] = instr_rom;
      rec_in[2] = datareg_wr_sig;
      rec_in[3] = (ena_wr_sig | ena_rd_sig) ? alu_result : dataram_wr_sig;
      rec_in[4] = {ena_wr_sig, ena_rd_sig, MemtoReg_mux, 5'b0, seq};

      rd_next   = rd_ptr + AW'(pop);
      idx_next  = idx;
      if (xfer) idx_next = tr_last ? 3'd0 : idx + 3'd1;

      // Only records already resident before this edge feed the output register,
      // which is why a record into an empty FIFO appears one edge after its push.
      kept      = level - LW'(pop);
      avail     = (kept != '0);
      head_next = mem[rd_next];
   end

   // NOTE: record storage has no reset; level and the pointers alone decide what is valid.
   always_ff @(posedge reloj) begin
      if (push) mem[wr_ptr] <= rec_in;
   end

   // NOTE: sequential state uses non-blocking assignments so every register sees pre-edge values.
   always_ff @(posedge reloj or negedge reset) begin
      if (!reset) begin
         st       <= IDLE;
         wr_ptr   <= '0;
         rd_ptr   <= '0;
         idx      <= 3'd0;
         level    <= '0;
         seq      <= 24'd0;
         rec_cnt  <= 32'd0;
         drop_cnt <= 16'd0;
         tr_valid <= 1'b0;
         tr_last  <= 1'b0;
         tr_data  <= 32'd0;
      end else begin
         if (stop_hit)     st <= DONE;
         else if (arm_hit) st <= ARMED;
         else if (sample)  st <= cap_end ? DONE : CAPTURE;

         if (arm_hit) begin
            seq      <= 24'd0;
            rec_cnt  <= 32'd0;
            drop_cnt <= 16'd0;
         end else if (sample) begin
            seq     <= seq + 24'd1;
            rec_cnt <= rec_cnt + 32'd1;
            if (!push && drop_cnt != 16'hFFFF) drop_cnt <= drop_cnt + 16'd1;
         end

         if (push) wr_ptr <= wr_ptr + AW'(1);
         rd_ptr <= rd_next;
         idx    <= idx_next;

         if (push && !pop)      level <= level + LW'(1);
         else if (pop && !push) level <= level - LW'(1);

         tr_valid <= avail;
         tr_last  <= avail & (idx_next == 3'd4);
         tr_data  <= avail ? head_next[idx_next] : 32'd0;
      end
   end

endmodule
